aes_iter_cipher: RTL and testbench
==================================

Name: aes_iter_cipher

Overview:
- Iterative AES encryption core. Performs one AES round per clock on a single 128-bit state register.
- Supersedes the single-shot combinational round: adds a parametrised round count, a distinct final round without MixColumns, a round-key fetch interface, and valid/ready handshakes on input and output.
- Round keys come from an external key-schedule store. This block contains no key expansion.
- Sits between the block-mode/IO controller and the ciphertext sink.

Parameters:
- NR, 10, number of rounds; legal values 10, 12, 14 (AES-128/192/256). Any other value is a synthesis-time error.
- RKW, 4, width of the round-key index. Must satisfy 2^RKW > NR.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext available.
- in_ready  out  1  core can accept plaintext.
- in_data  in  128  plaintext; bits [127:120] = byte 0 (row 0, col 0); column-major per FIPS-197.
- rk_idx  out  RKW  index of the round key needed this cycle.
- rk  in  128  round key rk[rk_idx]. Must be valid combinationally in the same cycle (zero-latency lookup). Same byte order as in_data.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  sink accepts ciphertext.
- out_data  out  128  ciphertext; equals the state register.
- busy  out  1  high in RUN or DONE.
- round_cnt  out  RKW  current round number (debug/verify).

Behaviour:
- Reset (async assert, released synchronously to clk):
  - FSM = IDLE; state = 0; round_cnt = 0; rk_idx = 0.
  - in_ready = 1; out_valid = 0; busy = 0; out_data = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1 and rk_idx = 0.
  - On in_valid & in_ready at an edge: state <= in_data ^ rk; round_cnt <= 1; go to RUN.
- RUN:
  - in_ready = 0; rk_idx = round_cnt.
  - Each edge:
    - If round_cnt < NR: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk).
    - If round_cnt == NR (final round): state <= AddRoundKey(ShiftRows(SubBytes(state)), rk). MixColumns is skipped.
    - round_cnt increments each round. On the final-round edge, go to DONE instead.
- DONE:
  - out_valid = 1; out_data stable; rk_idx = 0.
  - On out_ready at an edge: go to IDLE; round_cnt <= 0.
  - out_data keeps the last ciphertext until the next accept.
- Latency:
  - Accept edge = E0. out_valid goes high after edge E0+NR; that is 11 edges total for NR=10 (1 whitening edge + 10 round edges).
  - Minimum throughput: one block per NR+2 cycles.
- Handshake rules:
  - in_valid is ignored outside IDLE. No input buffering.
  - out_valid is held indefinitely until out_ready; there is no timeout.
  - In DONE, in_ready stays 0, even if out_ready is high in the same cycle. A new block can be accepted only the cycle after the out handshake.
  - in_data and rk are sampled only at the edges described above. in_data may change freely at other times.
- Arithmetic:
  - SubBytes uses the standard AES S-box on all 16 bytes.
  - ShiftRows: row r rotates left by r bytes.
  - MixColumns: GF(2^8) with polynomial 0x11b; xtime(b) = (b<<1) ^ (b[7] ? 0x1b : 0).
  - All operations are exactly 128-bit. No carries leave a byte.
- Boundary conditions:
  - rst during RUN or DONE aborts immediately. The partial state is cleared to 0, no out_valid pulse is issued, and the in-flight block is lost.
  - round_cnt never exceeds NR.

Test Plan:
- FIPS-197 C.1 (NR=10): in_data 00112233445566778899aabbccddeeff, rk from key 000102030405060708090a0b0c0d0e0f.
  - Required: out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_valid rises exactly 11 edges after accept; rk_idx sequence 1..10 during RUN.
- FIPS-197 App. B: in_data 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: state after accept = 193de3bea0f4e22b9ac68d2ae9f84808.
  - Required: state after round 1 = a49c7ff2689f352b6b5bea43026a5049.
  - Required: final out_data 3925841d02dc09fbdc118597196a0b32 (checks final round skips MixColumns).
- Back-pressure: hold out_ready=0 for 20 cycles after C.1 completes.
  - Required: out_valid=1 and out_data constant throughout; in_ready=0; a concurrent in_valid is not accepted.
  - Then out_ready=1 for 1 cycle → IDLE, in_ready=1 next cycle.
- Back-to-back: in_valid held high, out_ready tied high, vectors C.1 then App. B.
  - Required: two correct ciphertexts, accepts spaced NR+2 = 12 cycles apart.
- Reset mid-operation: assert rst at round_cnt=5 of App. B.
  - Required: immediately state=0, out_valid=0, in_ready=1, busy=0.
  - Required: no ciphertext emitted; a subsequent C.1 run still yields 69c4e0d86a7b0430d8cdb78070b4c55a.
- NR=14 instance: FIPS-197 C.3, key 000102...1e1f, same plaintext as C.1.
  - Required: out_data 8ea2b7ca516745bfeafc49904b496089 after 15 edges.

Source files
------------

// File: rtl/aes_iter_cipher_if.sv
// Bus bundle for the iterative AES core: plaintext in, round-key fetch, ciphertext out.
//
// Handshake semantics: a transfer happens on a rising clk edge where valid and
// ready are both high. Once valid is raised it stays high, with data stable,
// until that edge. ready may depend on state but never on the same-cycle valid.
// rk is a zero-latency lookup: the store drives rk = key[rk_idx] combinationally.
interface aes_iter_cipher_if #(
  parameter int RKW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic [RKW-1:0] rk_idx;
  logic [127:0]   rk;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;

  // Controller/key-store/sink side
  modport master (
    output in_valid, in_data, rk, out_ready,
    input  in_ready, rk_idx, out_valid, out_data
  );

  // Cipher core side
  modport slave (
    input  in_valid, in_data, rk, out_ready,
    output in_ready, rk_idx, out_valid, out_data
  );
endinterface

// File: rtl/aes_iter_cipher.sv
// Iterative AES encryption core: one round per clock on a single 128-bit state
// register. Round keys are fetched from an external store through rk_idx/rk.
module aes_iter_cipher #(
  parameter int NR  = 10,
  parameter int RKW = 4
) (
  input  logic             clk,
  input  logic             rst,
  aes_iter_cipher_if.slave bus,
  output logic             busy,
  output logic [RKW-1:0]   round_cnt,
  output logic [1:0]       fsm_state
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_iter_cipher: NR must be 10, 12 or 14");
  end
  if ((1 << RKW) <= NR) begin : g_bad_rkw
    $error("aes_iter_cipher: RKW too narrow to index round NR");
  end

  localparam logic [RKW-1:0] NR_IDX = RKW'(NR);

  // S-box, byte 0x00 in the top eight bits, 0xff in the bottom eight.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t           fsm;
  logic [127:0]   state;
  logic [RKW-1:0] rk_idx_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic [127:0]   sr_state;
  logic [127:0]   mc_state;
  logic [127:0]   round_next;

  // Entry for byte b sits at bit offset (255-b)*8, i.e. {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = {~b, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Byte (row, col) lives at index row + 4*col; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
    return r;
  endfunction

  // One cipher round; the last round drops MixColumns.
  always_comb begin
    sr_state   = shift_rows(sub_bytes(state));
    mc_state   = mix_columns(sr_state);
    round_next = ((round_cnt == NR_IDX) ? sr_state : mc_state) ^ bus.rk;
  end

  // Control FSM with the state register and all handshake outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= S_IDLE;
      state       <= '0;
      round_cnt   <= '0;
      rk_idx_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (bus.in_valid) begin
            // Whitening: initial AddRoundKey with rk[0].
            state      <= bus.in_data ^ bus.rk;
            round_cnt  <= RKW'(1);
            rk_idx_q   <= RKW'(1);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            fsm        <= S_RUN;
          end
        end
        S_RUN: begin
          state <= round_next;
          if (round_cnt == NR_IDX) begin
            // Final round: hold round_cnt at NR, park the key index.
            rk_idx_q    <= '0;
            out_valid_q <= 1'b1;
            fsm         <= S_DONE;
          end else begin
            round_cnt <= round_cnt + RKW'(1);
            rk_idx_q  <= round_cnt + RKW'(1);
          end
        end
        S_DONE: begin
          // in_ready returns one cycle after the output handshake.
          if (bus.out_ready) begin
            round_cnt   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            fsm         <= S_IDLE;
          end
        end
        default: begin
          fsm         <= S_IDLE;
          round_cnt   <= '0;
          rk_idx_q    <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = state;
  assign bus.rk_idx    = rk_idx_q;
  assign busy          = busy_q;
  assign fsm_state     = fsm;

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Bench for aes_iter_cipher: NR=10 and NR=14 instances, an independent AES
// model (S-box derived from GF(2^8) inverses, generic key expansion) and a
// per-cycle compare process with a ciphertext scoreboard.
module tb_aes_iter_cipher;

  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam int KS_C1 = 0;
  localparam int KS_B  = 1;
  localparam int KS_C3 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_iter_cipher_if #(.RKW(4)) if10 ();
  aes_iter_cipher_if #(.RKW(4)) if14 ();
  logic       busy10, busy14;
  logic [3:0] rc10, rc14;
  logic [1:0] fsm10, fsm14;

  aes_iter_cipher #(.NR(10), .RKW(4)) dut10 (
    .clk(clk), .rst(rst), .bus(if10), .busy(busy10), .round_cnt(rc10), .fsm_state(fsm10)
  );
  aes_iter_cipher #(.NR(14), .RKW(4)) dut14 (
    .clk(clk), .rst(rst), .bus(if14), .busy(busy14), .round_cnt(rc14), .fsm_state(fsm14)
  );

  // ---------------- model tables ----------------
  logic [7:0]   sbox_t [0:255];
  logic [127:0] ks_tab [0:2][0:15];
  int           cur_ks [0:1] = '{KS_C1, KS_C3};

  // Zero-latency key store feeding each core.
  assign if10.rk = ks_tab[cur_ks[0]][if10.rk_idx];
  assign if14.rk = ks_tab[cur_ks[1]][if14.rk_idx];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [7:0] mcoef(input int k);
    case (k)
      0: return 8'h02;
      1: return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Key in the top nk*32 bits of key.
  task automatic expand_key(input int ks, input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) ks_tab[ks][r] = '0;
    for (int r = 0; r <= nr; r++) ks_tab[ks][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // State after whitening plus k rounds, with the key set ks.
  function automatic logic [127:0] aes_state(input int ks, input logic [127:0] pt, input int k);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [7:0]   acc;
    logic [127:0] s;
    int nr;
    nr = (ks == KS_C3) ? 14 : 10;
    s = pt ^ ks_tab[ks][0];
    for (int r = 1; r <= k; r++) begin
      for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127 - 8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row + 4*c] = a[row + 4*((c + row) % 4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(mcoef((j - row + 4) % 4), t[4*c + j]);
            a[row + 4*c] = acc;
          end
        for (int i = 0; i < 16; i++) t[i] = a[i];
      end
      for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = t[i];
      s = s ^ ks_tab[ks][r];
    end
    return s;
  endfunction

  // ---------------- scoreboard / model state ----------------
  logic         m_idle [0:1] = '{1'b1, 1'b1};
  int           m_k    [0:1] = '{0, 0};
  int           m_ks   [0:1] = '{0, 2};
  logic [127:0] m_pt   [0:1];
  logic [127:0] m_exp  [0:1] = '{128'h0, 128'h0};
  logic [127:0] exp_q0 [$];
  logic [127:0] exp_q1 [$];
  int           acc_q  [$];
  int           ct_seen [0:1] = '{0, 0};
  int           cyc = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_step(input int d, input logic iv, input logic [127:0] idat, input logic ordy);
    int nr;
    logic [127:0] ct;
    nr = (d == 0) ? 10 : 14;
    if (m_idle[d]) begin
      if (iv) begin
        m_idle[d] = 1'b0;
        m_k[d]    = 0;
        m_pt[d]   = idat;
        m_ks[d]   = cur_ks[d];
        m_exp[d]  = aes_state(m_ks[d], idat, 0);
        ct = aes_state(m_ks[d], idat, nr);
        if (d == 0) begin
          exp_q0.push_back(ct);
          acc_q.push_back(cyc);
        end else begin
          exp_q1.push_back(ct);
        end
      end
    end else if (m_k[d] < nr) begin
      m_k[d]   = m_k[d] + 1;
      m_exp[d] = aes_state(m_ks[d], m_pt[d], m_k[d]);
    end else if (ordy) begin
      m_idle[d] = 1'b1;
    end
  endtask

  // Model advances on the same edges as the cores.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_idle[d] = 1'b1;
        m_k[d]    = 0;
        m_exp[d]  = '0;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      cyc++;
      model_step(0, if10.in_valid, if10.in_data, if10.out_ready);
      model_step(1, if14.in_valid, if14.in_data, if14.out_ready);
    end
  end

  task automatic compare_dut(input int d);
    logic ir, ov, bz, ordy;
    logic [3:0] rc, ri;
    logic [127:0] od, ct;
    int nr, exp_rc, exp_ri;
    string tag;
    if (d == 0) begin
      ir = if10.in_ready; ov = if10.out_valid; bz = busy10; rc = rc10;
      ri = if10.rk_idx; od = if10.out_data; ordy = if10.out_ready; nr = 10;
    end else begin
      ir = if14.in_ready; ov = if14.out_valid; bz = busy14; rc = rc14;
      ri = if14.rk_idx; od = if14.out_data; ordy = if14.out_ready; nr = 14;
    end
    tag = $sformatf("nr%0d", nr);
    exp_rc = m_idle[d] ? 0 : ((m_k[d] < nr) ? m_k[d] + 1 : nr);
    exp_ri = (!m_idle[d] && m_k[d] < nr) ? m_k[d] + 1 : 0;
    check({tag, " in_ready"}, 128'(ir), 128'(m_idle[d]));
    check({tag, " busy"}, 128'(bz), 128'(!m_idle[d]));
    check({tag, " out_valid"}, 128'(ov), 128'(!m_idle[d] && m_k[d] == nr));
    check({tag, " round_cnt"}, 128'(rc), 128'(exp_rc));
    check({tag, " rk_idx"}, 128'(ri), 128'(exp_ri));
    check({tag, " out_data"}, od, m_exp[d]);
    if (ov && ordy) begin
      if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s unexpected ciphertext: got %h expected none", tag, od);
      end else begin
        ct = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check({tag, " ciphertext"}, od, ct);
        ct_seen[d]++;
      end
    end
  endtask

  // Compare process: all outputs of both cores, every cycle, away from the edge.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) compare_dut(d);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ov_of(input int d);
    return (d == 0) ? if10.out_valid : if14.out_valid;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? busy10 : busy14;
  endfunction

  task automatic set_ordy(input int d, input logic v);
    if (d == 0) if10.out_ready = v; else if14.out_ready = v;
  endtask

  task automatic start_block(input int d, input int ks, input logic [127:0] pt);
    cur_ks[d] = ks;
    if (d == 0) begin if10.in_data = pt; if10.in_valid = 1'b1; end
    else begin if14.in_data = pt; if14.in_valid = 1'b1; end
    tick();
    if (d == 0) if10.in_valid = 1'b0; else if14.in_valid = 1'b0;
    check("accept busy", 128'(busy_of(d)), 128'(1));
  endtask

  task automatic wait_done(input int d, output int edges);
    edges = 0;
    while (!ov_of(d) && edges < 50) begin
      tick();
      edges++;
    end
    check("completion out_valid", 128'(ov_of(d)), 128'(1));
  endtask

  task automatic release_out(input int d);
    set_ordy(d, 1'b1);
    tick();
    set_ordy(d, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int edges;
  int guard;
  int base_seen;

  initial begin
    if10.in_valid = 1'b0; if10.in_data = '0; if10.out_ready = 1'b0;
    if14.in_valid = 1'b0; if14.in_data = '0; if14.out_ready = 1'b0;
    build_sbox();
    expand_key(KS_C1, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand_key(KS_B,  {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    expand_key(KS_C3, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    // Reset state
    tick();
    check("reset out_data", if10.out_data, 128'h0);
    check("reset in_ready", 128'(if10.in_ready), 128'(1));
    check("reset out_valid", 128'(if10.out_valid), 128'(0));
    check("reset busy", 128'(busy10), 128'(0));
    check("reset round_cnt", 128'(rc10), 128'(0));
    check("reset rk_idx", 128'(if10.rk_idx), 128'(0));
    tick();
    rst = 1'b0;

    // Literal pins on the model itself
    check("model sbox 00", 128'(sbox_t[8'h00]), 128'h63);
    check("model sbox 53", 128'(sbox_t[8'h53]), 128'hed);
    check("model rk10 appB", ks_tab[KS_B][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("model rk10 c1", ks_tab[KS_C1][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("model c1 ct", aes_state(KS_C1, PT_C1, 10), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("model appB round1", aes_state(KS_B, PT_B, 1), 128'ha49c7ff2689f352b6b5bea43026a5049);
    check("model c3 ct", aes_state(KS_C3, PT_C1, 14), 128'h8ea2b7ca516745bfeafc49904b496089);

    // C.1 with latency
    tick();
    start_block(0, KS_C1, PT_C1);
    wait_done(0, edges);
    check("c1 latency edges", 128'(edges + 1), 128'(11));
    check("c1 out_data", if10.out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Back-pressure with a concurrent in_valid
    if10.in_data = PT_B;
    if10.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp out_valid", 128'(if10.out_valid), 128'(1));
      check("bp out_data", if10.out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      check("bp in_ready", 128'(if10.in_ready), 128'(0));
    end
    release_out(0);
    if10.in_valid = 1'b0;
    check("bp idle in_ready", 128'(if10.in_ready), 128'(1));
    check("bp idle busy", 128'(busy10), 128'(0));
    check("bp idle out_valid", 128'(if10.out_valid), 128'(0));

    // App. B with intermediate states
    tick();
    start_block(0, KS_B, PT_B);
    check("appB whitened", if10.out_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    tick();
    check("appB round1", if10.out_data, 128'ha49c7ff2689f352b6b5bea43026a5049);
    wait_done(0, edges);
    check("appB latency edges", 128'(edges + 2), 128'(11));
    check("appB out_data", if10.out_data, 128'h3925841d02dc09fbdc118597196a0b32);
    release_out(0);

    // Back-to-back: in_valid held, out_ready tied high
    acc_q.delete();
    base_seen = ct_seen[0];
    set_ordy(0, 1'b1);
    cur_ks[0] = KS_C1;
    if10.in_data = PT_C1;
    if10.in_valid = 1'b1;
    guard = 0;
    while (!if10.out_valid && guard < 40) begin tick(); guard++; end
    cur_ks[0] = KS_B;
    if10.in_data = PT_B;
    guard = 0;
    while (acc_q.size() < 2 && guard < 40) begin tick(); guard++; end
    if10.in_valid = 1'b0;
    guard = 0;
    while ((busy10 || exp_q0.size() != 0) && guard < 40) begin tick(); guard++; end
    set_ordy(0, 1'b0);
    check("b2b accept count", 128'(acc_q.size()), 128'(2));
    if (acc_q.size() == 2) check("b2b accept spacing", 128'(acc_q[1] - acc_q[0]), 128'(12));
    check("b2b ciphertexts", 128'(ct_seen[0] - base_seen), 128'(2));

    // Reset mid-operation at round_cnt 5
    tick();
    start_block(0, KS_B, PT_B);
    guard = 0;
    while (rc10 != 4'd5 && guard < 20) begin tick(); guard++; end
    check("abort at round 5", 128'(rc10), 128'(5));
    rst = 1'b1;
    #1;
    check("abort out_data", if10.out_data, 128'h0);
    check("abort out_valid", 128'(if10.out_valid), 128'(0));
    check("abort in_ready", 128'(if10.in_ready), 128'(1));
    check("abort busy", 128'(busy10), 128'(0));
    tick();
    rst = 1'b0;
    tick();
    start_block(0, KS_C1, PT_C1);
    wait_done(0, edges);
    check("post-abort c1", if10.out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    release_out(0);

    // NR=14 instance, C.3
    tick();
    start_block(1, KS_C3, PT_C1);
    wait_done(1, edges);
    check("c3 latency edges", 128'(edges + 1), 128'(15));
    check("c3 out_data", if14.out_data, 128'h8ea2b7ca516745bfeafc49904b496089);
    release_out(1);
    tick();
    tick();

    check("scoreboard nr10 drained", 128'(exp_q0.size()), 128'(0));
    check("scoreboard nr14 drained", 128'(exp_q1.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
